// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a one-entry skid buffer and valid/ready handshake.
// Optional MEM_WB_STALL_CNT_EN adds stall_cnt_o, counting back-pressured cycles.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] wb_data_o
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    localparam int ENT_W = WB_W + 2 * DATA_W + REG_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [ENT_W-1:0]   main_reg;
    logic [ENT_W-1:0]   skid_reg;
    logic [ENT_W-1:0]   entry_in;
    logic [WB_W-1:0]    main_wb;

    logic               push;
    logic               pop;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    assign entry_in = {wb_i, read_data_i, addr_i, rd_i};

    // Flush and stall both mask the handshake, so the FSM only sees real transfers.
    assign push = in_valid_i & in_ready_reg & ~stall_i & ~flush_i;
    assign pop  = out_valid_reg & out_ready_i & ~stall_i & ~flush_i;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_next = S_EMPTY;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (push) begin
                        load_main_in = 1'b1;
                        state_next   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        load_skid  = 1'b1;
                        state_next = S_FULL;
                    end else if (pop) begin
                        state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_next     = S_ONE;
                    end
                end
                default: begin
                    state_next = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake flags are registered copies of the next state so both ports see flop outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != S_FULL);
            out_valid_reg <= (state_next != S_EMPTY);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main_in) begin
                main_reg <= entry_in;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= entry_in;
            end
        end
    end

    assign {main_wb, read_data_o, addr_o, rd_o} = main_reg;

    assign in_ready_o   = in_ready_reg;
    assign out_valid_o  = out_valid_reg;
    assign reg_write_o  = main_wb[WB_W-1] & out_valid_reg;
    assign mem_to_reg_o = main_wb[0];
    assign wb_data_o    = mem_to_reg_o ? read_data_o : addr_o;

`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Counts cycles where the WB side refuses a valid entry; sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (out_valid_reg && !out_ready_i && !stall_i && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
